pal_macrocell_array: RTL and testbench

Parametrised second-generation PAL core: a programmable AND plane over the primary inputs and registered-output feedback, an OR plane, and one macrocell per output. Each macrocell can be combinational or registered, with optional output inversion. Configuration is shifted in serially into a shadow chain. A separate commit atomically loads the chain into the active configuration, so logic keeps running from the old bitstream during reload. It sits directly under the TinyTapeout top wrapper: primary inputs come from the dedicated inputs, outputs drive the dedicated outputs, and config pins come from the bidirectional IOs.

---
 rtl/pal_macrocell_array_if.sv | 35 +++
 rtl/pal_macrocell_array.sv | 138 +++++++++++++
 tb/tb_pal_macrocell_array.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pal_macrocell_array_if.sv
// pal_macrocell_array_if
// Groups the PAL signal bundle: the macrocell enable, the serial
// configuration port, the primary inputs, the outputs and the status flags.
//   master : drives ena, cfg_en, cfg_data, cfg_commit and in_data;
//            observes out_data, cfg_count, cfg_done and cfg_err
//   slave  : the PAL core (the directions are the reverse of master)
interface pal_macrocell_array_if #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_OUTPUTS = 8,
  parameter int NUM_TERMS   = 8
);
  localparam int LW      = 2 * (NUM_INPUTS + NUM_OUTPUTS);
  localparam int CFG_LEN = NUM_TERMS * LW + NUM_TERMS * NUM_OUTPUTS + 2 * NUM_OUTPUTS;
  localparam int CW      = $clog2(CFG_LEN + 1);

  logic                   ena;
  logic                   cfg_en;
  logic                   cfg_data;
  logic                   cfg_commit;
  logic [NUM_INPUTS-1:0]  in_data;
  logic [NUM_OUTPUTS-1:0] out_data;
  logic [CW-1:0]          cfg_count;
  logic                   cfg_done;
  logic                   cfg_err;

  modport master (
    output ena, cfg_en, cfg_data, cfg_commit, in_data,
    input  out_data, cfg_count, cfg_done, cfg_err
  );

  modport slave (
    input  ena, cfg_en, cfg_data, cfg_commit, in_data,
    output out_data, cfg_count, cfg_done, cfg_err
  );
endinterface

// File: rtl/pal_macrocell_array.sv
// pal_macrocell_array
// Programmable AND/OR array with one macrocell per output. Each macrocell is
// either combinational or registered, with optional inversion. The
// configuration is shifted serially into a shadow chain. A commit copies the
// shadow chain into the active configuration in one step, so the logic keeps
// running from the old configuration while a new one is being shifted in.
// Ports:
//   clk   : system clock; all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pal_macrocell_array_if.slave. It carries ena, cfg_en, cfg_data,
//           cfg_commit, in_data, out_data, cfg_count, cfg_done and cfg_err.
module pal_macrocell_array #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_OUTPUTS = 8,
  parameter int NUM_TERMS   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pal_macrocell_array_if.slave  bus
);
  localparam int NI      = NUM_INPUTS;
  localparam int NO      = NUM_OUTPUTS;
  localparam int NT      = NUM_TERMS;
  localparam int NV      = NI + NO;
  localparam int LW      = 2 * NV;
  localparam int OB      = NT * LW;
  localparam int MB      = OB + NT * NO;
  localparam int CFG_LEN = MB + 2 * NO;
  localparam int CW      = $clog2(CFG_LEN + 1);

  logic [CFG_LEN-1:0] shadow_r;
  logic [CFG_LEN-1:0] active_r;
  logic [NO-1:0]      q_r;
  logic [CW-1:0]      cfg_count_r;
  logic               cfg_done_r;
  logic               cfg_err_r;

  logic [NV-1:0]      v_s;
  logic [NT-1:0]      term_s;
  logic [NO-1:0]      sum_s;
  logic [NO-1:0]      out_s;
  logic               lit_any_s;
  logic               lit_and_s;
  logic [CW-1:0]      cnt_next_s;
  logic               err_next_s;
  logic               commit_ok_s;

  // Feedback is taken from q even for combinational macrocells, so the array has no combinational loop.
  assign v_s = {q_r, bus.in_data};

  // AND plane: each term is the AND of its selected literals. A term with no literal selected is 0, not 1.
  always_comb begin
    term_s    = {NT{1'b0}};
    lit_any_s = 1'b0;
    lit_and_s = 1'b1;
    for (int t = 0; t < NT; t++) begin
      lit_any_s = 1'b0;
      lit_and_s = 1'b1;
      for (int j = 0; j < NV; j++) begin
        lit_any_s = lit_any_s | active_r[t*LW + 2*j] | active_r[t*LW + 2*j + 1];
        lit_and_s = lit_and_s & (~active_r[t*LW + 2*j] | v_s[j])
                              & (~active_r[t*LW + 2*j + 1] | ~v_s[j]);
      end
      term_s[t] = lit_any_s & lit_and_s;
    end
  end

  // OR plane and macrocell output selection.
  always_comb begin
    sum_s = {NO{1'b0}};
    out_s = {NO{1'b0}};
    for (int o = 0; o < NO; o++) begin
      sum_s[o] = (|(term_s & active_r[OB + o*NT +: NT])) ^ active_r[MB + 2*o + 1];
      out_s[o] = active_r[MB + 2*o] ? q_r[o] : sum_s[o];
    end
  end

  // Next state of the configuration counter and error flag. A shift takes priority over a commit.
  always_comb begin
    cnt_next_s  = cfg_count_r;
    err_next_s  = cfg_err_r;
    commit_ok_s = 1'b0;
    if (bus.cfg_en) begin
      if (cfg_count_r == CW'(CFG_LEN)) begin
        err_next_s = 1'b1;
      end else begin
        cnt_next_s = cfg_count_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end else if (bus.cfg_commit) begin
      cnt_next_s = {CW{1'b0}};
      if (cfg_done_r) begin
        commit_ok_s = 1'b1;
        err_next_s  = 1'b0;
      end else begin
        err_next_s  = 1'b1;
      end
    end else begin
      cnt_next_s = cfg_count_r;
    end
  end

  // Configuration state: the shadow shift chain, the active copy, the counter and the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r    <= {CFG_LEN{1'b0}};
      active_r    <= {CFG_LEN{1'b0}};
      cfg_count_r <= {CW{1'b0}};
      cfg_done_r  <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      if (bus.cfg_en) begin
        shadow_r <= {bus.cfg_data, shadow_r[CFG_LEN-1:1]};
      end
      if (commit_ok_s) begin
        active_r <= shadow_r;
      end
      cfg_count_r <= cnt_next_s;
      cfg_done_r  <= (cnt_next_s == CW'(CFG_LEN));
      cfg_err_r   <= err_next_s;
    end
  end

  // Macrocell registers: a successful commit clears them so the new configuration starts from a known state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= {NO{1'b0}};
    end else if (commit_ok_s) begin
      q_r <= {NO{1'b0}};
    end else if (bus.ena) begin
      q_r <= sum_s;
    end
  end

  assign bus.out_data  = out_s;
  assign bus.cfg_count = cfg_count_r;
  assign bus.cfg_done  = cfg_done_r;
  assign bus.cfg_err   = cfg_err_r;
endmodule

// File: tb/tb_pal_macrocell_array.sv
// tb_pal_macrocell_array
// Scoreboard bench for pal_macrocell_array with the default parameters (8/8/8).
// It pushes expected values into a queue when it drives stimulus. It pops each
// value and compares it through check_value when it samples the DUT.
module tb_pal_macrocell_array;
  localparam int CFG_LEN = 336;

  logic clk;
  logic rst_n;

  pal_macrocell_array_if #(.NUM_INPUTS(8), .NUM_OUTPUTS(8), .NUM_TERMS(8)) bus ();

  pal_macrocell_array #(.NUM_INPUTS(8), .NUM_OUTPUTS(8), .NUM_TERMS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        n_checks;
  int        n_errors;

  logic [CFG_LEN-1:0] cfg_a;
  logic [CFG_LEN-1:0] cfg_b;
  logic [CFG_LEN-1:0] cfg_c;
  logic [CFG_LEN-1:0] cfg_z;
  logic [CFG_LEN-1:0] cfg_p;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog that stops a run that never finishes.
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    sb_entry_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] obs);
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      check_value("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_value(e.tag, obs, e.val);
    end
  endtask

  // Push an expected value and compare it against the current observation.
  task automatic expect_out(input string tag, input logic [31:0] exp);
    sb_push(tag, exp);
    #1;
    sb_pop_check(32'(bus.out_data));
  endtask

  task automatic expect_flags(input string tag, input int cnt, input logic done, input logic err);
    sb_push({tag, "_count"}, 32'(cnt));
    sb_push({tag, "_done"},  32'(done));
    sb_push({tag, "_err"},   32'(err));
    #1;
    sb_pop_check(32'(bus.cfg_count));
    sb_pop_check(32'(bus.cfg_done));
    sb_pop_check(32'(bus.cfg_err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [CFG_LEN-1:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      bus.cfg_en   = 1'b1;
      bus.cfg_data = (k < CFG_LEN) ? bits[k] : 1'b0;
      tick();
    end
    bus.cfg_en   = 1'b0;
    bus.cfg_data = 1'b0;
  endtask

  task automatic commit();
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
  endtask

  task automatic load(input logic [CFG_LEN-1:0] bits);
    shift_bits(bits, CFG_LEN);
    commit();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cfg_a = '0; cfg_a[0] = 1'b1; cfg_a[2] = 1'b1; cfg_a[256] = 1'b1;
    cfg_b = '0; cfg_b[17] = 1'b1; cfg_b[256] = 1'b1; cfg_b[320] = 1'b1;
    cfg_c = '0; cfg_c[321] = 1'b1;
    cfg_z = '0;
    cfg_p = '0; cfg_p[85] = 1'b1;

    rst_n          = 1'b0;
    bus.ena        = 1'b0;
    bus.cfg_en     = 1'b0;
    bus.cfg_data   = 1'b0;
    bus.cfg_commit = 1'b0;
    bus.in_data    = 8'hFF;

    // Reset state.
    expect_out("reset_out", 32'h00);
    expect_flags("reset", 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // AND/OR plane: out0 = in0 & in1, combinational.
    shift_bits(cfg_a, CFG_LEN);
    expect_flags("a_loaded", CFG_LEN, 1'b1, 1'b0);
    commit();
    expect_flags("a_commit", 0, 1'b0, 1'b0);
    bus.in_data = 8'h03; expect_out("a_in03", 32'h01);
    bus.in_data = 8'h01; expect_out("a_in01", 32'h00);
    bus.in_data = 8'hFF; expect_out("a_inFF", 32'h01);
    bus.in_data = 8'h02; expect_out("a_in02", 32'h00);

    // Registered toggle: out0 = q0, next q0 = ~q0.
    load(cfg_b);
    expect_out("b_commit", 32'h00);
    bus.ena = 1'b1;
    tick(); expect_out("b_edge1", 32'h01);
    tick(); expect_out("b_edge2", 32'h00);
    tick(); expect_out("b_edge3", 32'h01);
    bus.ena = 1'b0;
    tick(); expect_out("b_hold1", 32'h01);
    tick(); expect_out("b_hold2", 32'h01);
    bus.ena = 1'b1;
    tick();
    bus.ena = 1'b0;
    expect_out("b_back0", 32'h00);

    // Reload while running: the old function holds until the commit edge.
    shift_bits(cfg_c, 150);
    expect_out("c_mid_load", 32'h00);
    expect_flags("c_mid", 150, 1'b0, 1'b0);
    shift_bits(cfg_c >> 150, CFG_LEN - 150);
    expect_out("c_pre_commit", 32'h00);
    commit();
    expect_out("c_inverted", 32'h01);

    // Over-shift sets the error flag and saturates the count.
    shift_bits(cfg_z, CFG_LEN);
    expect_flags("full", CFG_LEN, 1'b1, 1'b0);
    shift_bits(cfg_z, 1);
    expect_flags("over", CFG_LEN, 1'b1, 1'b1);
    commit();
    expect_flags("over_commit", 0, 1'b0, 1'b0);
    expect_out("zero_active", 32'h00);

    // Early commit: the active configuration must not change.
    shift_bits(cfg_p, 100);
    commit();
    expect_flags("early", 0, 1'b0, 1'b1);
    expect_out("early_keep", 32'h00);

    // A commit in the same cycle as a shift is ignored.
    load(cfg_c);
    expect_out("c2_active", 32'h01);
    expect_flags("c2", 0, 1'b0, 1'b0);
    bus.in_data = 8'h01;
    shift_bits(cfg_a, CFG_LEN - 1);
    bus.cfg_en     = 1'b1;
    bus.cfg_data   = cfg_a[CFG_LEN-1];
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_en     = 1'b0;
    bus.cfg_commit = 1'b0;
    expect_flags("en_commit", CFG_LEN, 1'b1, 1'b0);
    expect_out("en_commit_keep", 32'h01);
    commit();
    expect_out("a2_in01", 32'h00);
    bus.in_data = 8'h03; expect_out("a2_in03", 32'h01);

    // Asynchronous reset mid-shift and with active outputs.
    commit();
    expect_flags("pre_rst_err", 0, 1'b0, 1'b1);
    shift_bits(cfg_c, 150);
    expect_flags("pre_rst", 150, 1'b0, 1'b1);
    rst_n = 1'b0;
    expect_out("rst_async_out", 32'h00);
    expect_flags("rst_async", 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    expect_out("rst_active_clear", 32'h00);

    check_value("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
